// File: rtl/neuron_mac_accumulator_if.sv
// Handshake bundle for neuron_mac_accumulator: input beats (x, w, bias) and held result (y, sat).
// Strict valid/ready on both sides: a transfer occurs on a rising edge where valid && ready.
interface neuron_mac_accumulator_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] x;
    logic [N-1:0] w;
    logic [N-1:0] bias;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] y;
    logic         sat;

    modport master (
        output in_valid, x, w, bias, out_ready,
        input  in_ready, out_valid, y, sat
    );

    modport slave (
        input  in_valid, x, w, bias, out_ready,
        output in_ready, out_valid, y, sat
    );
endinterface

// File: rtl/neuron_mac_accumulator.sv
// Fixed-point MAC: K signed x*w products plus bias, shifted by FRAC, saturated to N bits.
// Optional macro NEURON_RELU_EN replaces a negative saturated result by zero.
module neuron_mac_accumulator #(
    parameter int N     = 16,
    parameter int K     = 8,
    parameter int FRAC  = 8,
    parameter int ACC_W = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    neuron_mac_accumulator_if.slave  bus,
    output logic [1:0]               o_dbg_state
);
    localparam int CNT_W = $clog2(K) + 1;
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - N){1'b0}}, {(N - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W + 2 - N){1'b1}}, {(N - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    state_t                   r_state;
    logic                     r_drain_done;
    logic signed [2*N-1:0]    r_prod;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [N-1:0]      r_bias;
    logic [CNT_W-1:0]         r_count;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic [N-1:0]             r_y;
    logic                     r_sat;

    logic                     w_accept;
    logic signed [2*N-1:0]    w_x_ext;
    logic signed [2*N-1:0]    w_w_ext;
    logic signed [2*N-1:0]    w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_shift;
    logic signed [ACC_W:0]    w_sum;
    logic [N-1:0]             w_clamped;
    logic                     w_clip;
    logic [N-1:0]             w_result;

    assign w_accept   = bus.in_valid && r_in_ready;
    assign w_x_ext    = {{N{bus.x[N-1]}}, bus.x};
    assign w_w_ext    = {{N{bus.w[N-1]}}, bus.w};
    assign w_prod     = w_x_ext * w_w_ext;
    assign w_prod_ext = {{(ACC_W - 2*N){r_prod[2*N-1]}}, r_prod};
    assign w_shift    = r_acc >>> FRAC;
    // One guard bit keeps the bias add from wrapping before the clamp.
    assign w_sum      = {w_shift[ACC_W-1], w_shift} + {{(ACC_W + 1 - N){r_bias[N-1]}}, r_bias};

    always_comb begin
        w_clamped = w_sum[N-1:0];
        w_clip    = 1'b0;
        if (w_sum > SAT_MAX) begin
            w_clamped = {1'b0, {(N - 1){1'b1}}};
            w_clip    = 1'b1;
        end else if (w_sum < SAT_MIN) begin
            w_clamped = {1'b1, {(N - 1){1'b0}}};
            w_clip    = 1'b1;
        end
`ifdef NEURON_RELU_EN
        w_result = w_clamped[N-1] ? '0 : w_clamped;
`else
        w_result = w_clamped;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_drain_done <= 1'b0;
            r_prod       <= '0;
            r_acc        <= '0;
            r_bias       <= '0;
            r_count      <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_y          <= '0;
            r_sat        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_acc   <= '0;
                        r_bias  <= bus.bias;
                        r_prod  <= w_prod;
                        r_count <= CNT_W'(1);
                        if (K == 1) begin
                            r_state    <= DRAIN;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        r_acc   <= r_acc + w_prod_ext;
                        r_prod  <= w_prod;
                        r_count <= r_count + CNT_W'(1);
                        if (r_count == CNT_W'(K - 1)) begin
                            r_state    <= DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // First cycle folds in the final product, second registers the result.
                    if (!r_drain_done) begin
                        r_acc        <= r_acc + w_prod_ext;
                        r_drain_done <= 1'b1;
                    end else begin
                        r_y          <= w_result;
                        r_sat        <= w_clip;
                        r_out_valid  <= 1'b1;
                        r_drain_done <= 1'b0;
                        r_state      <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_count     <= '0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.y         = r_y;
    assign bus.sat       = r_sat;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Directed bench for neuron_mac_accumulator (N=16, K=4, FRAC=8); honours NEURON_RELU_EN.
module tb_neuron_mac_accumulator;
    localparam int N     = 16;
    localparam int K     = 4;
    localparam int FRAC  = 8;
    localparam int ACC_W = 40;

`ifdef NEURON_RELU_EN
    localparam logic [N-1:0] EXP_NEG    = 16'h0000;
    localparam logic [N-1:0] EXP_SATNEG = 16'h0000;
`else
    localparam logic [N-1:0] EXP_NEG    = 16'hFC00;
    localparam logic [N-1:0] EXP_SATNEG = 16'h8000;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    int         tests_run    = 0;
    int         tests_failed = 0;
    logic       mon_en       = 1'b0;
    logic [N-1:0] got_q[$];

    always #5 clk = ~clk;

    neuron_mac_accumulator_if #(.N(N)) bus ();

    neuron_mac_accumulator #(
        .N(N), .K(K), .FRAC(FRAC), .ACC_W(ACC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .o_dbg_state(dbg_state)
    );

    always @(negedge clk) begin
        if (mon_en && bus.out_valid && bus.out_ready) got_q.push_back(bus.y);
    end

    task automatic send_beat(input logic [N-1:0] bx, input logic [N-1:0] bw, input logic [N-1:0] bb);
        int n;
        bus.x        = bx;
        bus.w        = bw;
        bus.bias     = bb;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            tests_run++; tests_failed++;
            $display("FAIL beat_accept_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_neuron(input logic [N-1:0] bx, input logic [N-1:0] bw, input logic [N-1:0] bb,
                               input logic [N-1:0] later_bias, input int gap, input logic hold);
        for (int i = 0; i < K; i++) begin
            send_beat(bx, bw, (i == 0) ? bb : later_bias);
            if (gap > 0 && i < K - 1) begin
                bus.in_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!bus.out_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.out_valid) begin
            tests_run++; tests_failed++;
            $display("FAIL out_valid_timeout: out_valid=%0b after %0d cycles, required 1", bus.out_valid, n);
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x = '0; bus.w = '0; bus.bias = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.y !== 16'h0000 ||
            bus.sat !== 1'b0 || dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b y=%h sat=%b state=%0d, required 0 0 0000 0 0",
                     bus.in_ready, bus.out_valid, bus.y, bus.sat, dbg_state);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_before_edge: in_ready=%b, required 0", bus.in_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_first_edge: in_ready=%b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        send_neuron(16'h0100, 16'h0200, 16'h0080, 16'h0080, 0, 1'b0);
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_lat_t0: out_valid=%b in_ready=%b, required 0 0", bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_lat_t1: out_valid=%b, required 0", bus.out_valid);
        end
        @(posedge clk); #1;
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.y !== 16'h0880 || bus.sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_lat_t2: out_valid=%b y=%h sat=%b, required 1 0880 0", bus.out_valid, bus.y, bus.sat);
        end
        @(posedge clk); #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL basic_handshake: out_valid=%b in_ready=%b state=%0d, required 0 1 0",
                     bus.out_valid, bus.in_ready, dbg_state);
        end
    endtask

    task automatic test_value(input logic [N-1:0] bx, input logic [N-1:0] bw, input logic [N-1:0] exp_y,
                              input logic exp_sat, input int gap);
        bus.out_ready = 1'b1;
        send_neuron(bx, bw, 16'h0000, 16'h0000, gap, 1'b0);
        wait_out();
        tests_run++;
        if (bus.y !== exp_y || bus.sat !== exp_sat) begin
            tests_failed++;
            $display("FAIL value x=%h w=%h gap=%0d: y=%h sat=%b, required y=%h sat=%b",
                     bx, bw, gap, bus.y, bus.sat, exp_y, exp_sat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bubbles();
        bus.out_ready = 1'b1;
        send_neuron(16'h0100, 16'h0200, 16'h0080, 16'h0080, 3, 1'b0);
        wait_out();
        tests_run++;
        if (bus.y !== 16'h0880 || bus.sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL bubbles: y=%h sat=%b, required 0880 0", bus.y, bus.sat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        send_neuron(16'h0100, 16'h0200, 16'h0080, 16'h0080, 0, 1'b0);
        wait_out();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.y !== 16'h0880 || bus.in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL backpressure_hold c=%0d: out_valid=%b y=%h in_ready=%b, required 1 0880 0",
                         c, bus.out_valid, bus.y, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        send_beat(16'h0100, 16'h0200, 16'h0080);
        send_beat(16'h0100, 16'h0200, 16'h0080);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.y !== 16'h0000 ||
            bus.sat !== 1'b0 || dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: in_ready=%b out_valid=%b y=%h sat=%b state=%0d, required 0 0 0000 0 0",
                     bus.in_ready, bus.out_valid, bus.y, bus.sat, dbg_state);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        send_neuron(16'h0100, 16'h0200, 16'h0080, 16'h0080, 0, 1'b0);
        wait_out();
        tests_run++;
        if (bus.y !== 16'h0880 || bus.sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_fresh: y=%h sat=%b, required 0880 0", bus.y, bus.sat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int n;
        got_q.delete();
        bus.out_ready = 1'b1;
        mon_en = 1'b1;
        send_neuron(16'h0100, 16'h0200, 16'h0080, 16'h7777, 0, 1'b1);
        send_neuron(16'h0100, 16'hFF00, 16'h0000, 16'h7777, 0, 1'b0);
        n = 0;
        while (got_q.size() < 2 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        mon_en = 1'b0;
        tests_run++;
        if (got_q.size() != 2) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d results, required 2", got_q.size());
        end else begin
            tests_run++;
            if (got_q[0] !== 16'h0880) begin
                tests_failed++;
                $display("FAIL b2b_first: y=%h, required 0880", got_q[0]);
            end
            tests_run++;
            if (got_q[1] !== EXP_NEG) begin
                tests_failed++;
                $display("FAIL b2b_second: y=%h, required %h", got_q[1], EXP_NEG);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_value(16'h0100, 16'hFF00, EXP_NEG, 1'b0, 0);
        test_value(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 0);
        test_value(16'h8000, 16'h7FFF, EXP_SATNEG, 1'b1, 0);
        test_bubbles();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
